vec_accum: RTL
==============

VEC_ACCUM -- requirements
Module: vec_accum

Interface
REQ-001 SHALL have parameter ARR_WIDTH, default 4, number of lanes per vector.
REQ-002 SHALL have parameter FXP_N, default 16, signed fixed-point lane width in bits.
REQ-003 SHALL have parameter LEN_W, default 8, width of the job-length field.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
REQ-008 len  input  LEN_W  number of vectors to accumulate; sampled when start is honoured.
REQ-009 in_valid  input  1  in_vec holds a valid vector.
REQ-010 in_ready  output  1  block accepts in_vec this cycle.
REQ-011 in_vec  input  signed [ARR_WIDTH][FXP_N]  vector sum produced by the upstream vec_add stage.
REQ-012 out_valid  output  1  out_vec holds the finished accumulation.
REQ-013 out_ready  input  1  consumer accepts out_vec this cycle.
REQ-014 out_vec  output  signed [ARR_WIDTH][FXP_N]  per-lane accumulated result.
REQ-015 out_sat  output  [ARR_WIDTH]  sticky per-lane flag, set if the lane saturated at any point during the job.
REQ-016 busy  output  1  high in ACCUM and OUT.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ACCUM and OUT.
REQ-018 IDLE->ACCUM on start with len!=0: accumulator cleared to 0, out_sat cleared, remaining count loaded with len.
REQ-019 start with len==0 SHALL be ignored; the FSM stays in IDLE.
REQ-020 start in ACCUM or OUT SHALL be ignored, with no effect on any state.
REQ-021 in_ready SHALL be 1 only in ACCUM; a handshake occurs when in_valid && in_ready at the rising edge.
REQ-022 Each handshake: per lane, form acc+in_vec at FXP_N+1 bits, clamp to [-2^(FXP_N-1), 2^(FXP_N-1)-1], store the result, and OR the overflow indication into out_sat.
REQ-023 Saturation SHALL be applied at every add, not only at the end; the result is therefore order-dependent, and that is intended.
REQ-024 Each handshake SHALL decrement the remaining count; a handshake when the count equals 1 SHALL move the FSM ACCUM->OUT.
REQ-025 in_valid low in ACCUM SHALL stall with no state change; throughput SHALL be one vector per cycle.
REQ-026 OUT: out_valid=1, out_vec=accumulator, out_sat held; in_ready=0.
REQ-027 out_valid SHALL rise in the cycle after the final input handshake (latency 1).
REQ-028 OUT->IDLE on out_ready; out_vec and out_sat SHALL stay stable while out_valid && !out_ready.
REQ-029 out_valid SHALL be 0 outside OUT; out_vec and out_sat keep their last value in IDLE until the next honoured start.
REQ-030 A start pulse in the same cycle as the OUT->IDLE handshake SHALL be ignored; start is honoured only from IDLE.

Reset
REQ-031 reset_n low SHALL immediately force the FSM to IDLE, the accumulator and out_vec to 0, out_sat to 0, the remaining count to 0, and out_valid, in_ready and busy to 0.
REQ-032 Reset mid-job SHALL discard the job with no partial output; the first honoured start after release SHALL behave as from power-up.

Verification (ARR_WIDTH=4, FXP_N=16)
REQ-033 start, len=2; in_vec {1,2,3,4} then {4,3,2,1} back-to-back -> out_vec {5,5,5,5}, out_sat 0000, out_valid 1 cycle after the 2nd handshake.
REQ-034 len=2; {32766,-32767,0,-1} then {3,-3,32767,-32768} -> out_vec {32767,-32768,32767,-32768}, out_sat lanes {1,1,0,1}.
REQ-035 Completed job with out_ready held low 5 cycles plus a start pulse mid-hold -> out_vec stable, in_ready=0, start ignored, IDLE after out_ready.
REQ-036 len=3 with in_valid gaps of 2 cycles between vectors {10,-20,30,-40},{-1,2,-3,4},{0,0,0,0} -> out_vec {9,-18,27,-36}, exactly 3 handshakes counted.
REQ-037 reset_n pulsed low after 1 of 3 inputs -> all outputs 0 and IDLE; a new job len=1 with {7,7,7,7} -> out_vec {7,7,7,7}.
REQ-038 start with len=0 -> busy stays 0, in_ready stays 0, no out_valid.

Source files
------------

// File: rtl/vec_accum.sv
// Vector accumulator: sums a job of `len` signed fixed-point vectors lane by lane,
// saturating at every add, and presents the result with a sticky per-lane saturation flag.
module vec_accum #(
    parameter int ARR_WIDTH = 4,
    parameter int FXP_N     = 16,
    parameter int LEN_W     = 8
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [LEN_W-1:0]                        len,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0]  in_vec,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [ARR_WIDTH-1:0][FXP_N-1:0]  out_vec,
    output logic [ARR_WIDTH-1:0]                    out_sat,
    output logic                                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic [LEN_W-1:0]                     remaining;
    logic signed [ARR_WIDTH-1:0][FXP_N-1:0] acc;
    logic signed [ARR_WIDTH-1:0][FXP_N-1:0] acc_sum;
    logic [ARR_WIDTH-1:0]                 sat;
    logic [ARR_WIDTH-1:0]                 lane_ovf;
    logic                                 load;
    logic                                 take;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_next = ACCUM;
                    load       = 1'b1;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (remaining == LEN_W'(1))) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign take = in_valid && in_ready;

    // One extra bit per lane catches overflow: the top two bits disagree exactly when the sum left range.
    for (genvar i = 0; i < ARR_WIDTH; i++) begin : g_lane
        logic [FXP_N:0] wide;
        assign wide        = {acc[i][FXP_N-1], acc[i]} + {in_vec[i][FXP_N-1], in_vec[i]};
        assign lane_ovf[i] = wide[FXP_N] ^ wide[FXP_N-1];
        assign acc_sum[i]  = !lane_ovf[i] ? wide[FXP_N-1:0]
                           : wide[FXP_N] ? {1'b1, {(FXP_N-1){1'b0}}}
                           :               {1'b0, {(FXP_N-1){1'b1}}};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            sat       <= '0;
            remaining <= '0;
        end else if (load) begin
            acc       <= '0;
            sat       <= '0;
            remaining <= len;
        end else if (take) begin
            acc       <= acc_sum;
            sat       <= sat | lane_ovf;
            remaining <= remaining - LEN_W'(1);
        end
    end

    // The accumulator only moves on handshakes, so it doubles as the held output in OUT and IDLE.
    assign out_vec = acc;
    assign out_sat = sat;

endmodule
